eth_test_frame_gen: RTL and testbench

//  Test-frame source for the RGMII MAC-with-FIFO path. Drives the MAC TX AXI-Stream input
//  (8-bit, clk/rst logic domain) with fixed-header Ethernet frames carrying a 32-bit sequence number
//  and an incrementing payload. Runs continuously when enabled, or sends single shots on trigger.
//  The MAC adds padding/FCS; this block emits header + payload only.

---
 rtl/eth_test_frame_gen.sv | 150 +++++++++++++++
 tb/tb_eth_test_frame_gen.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_test_frame_gen.sv
// rtl/eth_test_frame_gen.sv - fixed-header Ethernet test frame source for the MAC TX stream
module eth_test_frame_gen #(
   parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
   parameter logic [47:0] SRC_MAC     = 48'h0200_0000_0001,
   parameter logic [15:0] ETHERTYPE   = 16'h88B5,
   parameter int unsigned PAYLOAD_LEN = 46,
   parameter int unsigned GAP_CYCLES  = 12_500_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        trigger,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic        m_axis_tuser,
   output logic        busy,
   output logic [31:0] frame_count
);

   localparam int unsigned FRAME_LEN = 14 + PAYLOAD_LEN;
   localparam int unsigned BW        = $clog2(FRAME_LEN);
   localparam int unsigned GW_RAW    = $clog2(GAP_CYCLES + 1);
   localparam int unsigned GW        = (GW_RAW < 1) ? 1 : GW_RAW;
   localparam logic [BW-1:0] LAST_IDX = BW'(FRAME_LEN - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [111:0]  HDR_BYTES = {DST_MAC, SRC_MAC, ETHERTYPE};

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_SEQ, S_PAYLOAD, S_GAP} state_t;

   state_t         state;
   logic [BW-1:0]  byte_cnt;
   logic [GW-1:0]  gap_cnt;
   logic [31:0]    seq;
   logic [BW-1:0]  nxt_idx;
   state_t         nxt_state;

   // Byte value at a given frame position: header, then sequence number, then k mod 256
   function automatic logic [7:0] frame_byte(input logic [BW-1:0] idx, input logic [31:0] s);
      int unsigned  i;
      logic [111:0] h;
      logic [31:0]  q;
      int unsigned  k;
      i = 32'(idx);
      h = '0;
      q = '0;
      k = 0;
      if (i < 14) begin
         h = HDR_BYTES >> (8 * (13 - i));
         frame_byte = h[7:0];
      end else if (i < 18) begin
         q = s >> (8 * (17 - i));
         frame_byte = q[7:0];
      end else begin
         k = i - 18;
         frame_byte = k[7:0];
      end
   endfunction

   assign m_axis_tuser = 1'b0;

   // Position and section of the byte that follows the one currently presented
   always_comb begin
      nxt_idx   = byte_cnt + 1'b1;
      nxt_state = S_PAYLOAD;
      if (32'(nxt_idx) < 14)
         nxt_state = S_HDR;
      else if (32'(nxt_idx) < 18)
         nxt_state = S_SEQ;
   end

   // Frame sequencer: all stream outputs are registered; a byte only advances on handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         byte_cnt      <= '0;
         gap_cnt       <= '0;
         seq           <= '0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         busy          <= 1'b0;
         frame_count   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (enable || trigger) begin
                  state         <= S_HDR;
                  seq           <= frame_count;
                  byte_cnt      <= '0;
                  m_axis_tdata  <= HDR_BYTES[111:104];
                  m_axis_tlast  <= 1'b0;
                  m_axis_tvalid <= 1'b1;
                  busy          <= 1'b1;
               end
            end
            S_HDR, S_SEQ, S_PAYLOAD: begin
               if (m_axis_tvalid && m_axis_tready) begin
                  if (m_axis_tlast) begin
                     m_axis_tvalid <= 1'b0;
                     m_axis_tlast  <= 1'b0;
                     byte_cnt      <= '0;
                     frame_count   <= frame_count + 32'd1;
                     if (!enable) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                     end else if (GAP_CYCLES == 0) begin
                        // No gap: the next frame's first byte follows straight on
                        state         <= S_HDR;
                        seq           <= frame_count + 32'd1;
                        m_axis_tdata  <= HDR_BYTES[111:104];
                        m_axis_tvalid <= 1'b1;
                     end else begin
                        state   <= S_GAP;
                        gap_cnt <= '0;
                     end
                  end else begin
                     byte_cnt     <= nxt_idx;
                     m_axis_tdata <= frame_byte(nxt_idx, seq);
                     m_axis_tlast <= (nxt_idx == LAST_IDX);
                     state        <= nxt_state;
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  if (enable) begin
                     state         <= S_HDR;
                     seq           <= frame_count;
                     byte_cnt      <= '0;
                     m_axis_tdata  <= HDR_BYTES[111:104];
                     m_axis_tvalid <= 1'b1;
                  end else begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eth_test_frame_gen.sv
// tb/tb_eth_test_frame_gen.sv - directed self-checking bench for eth_test_frame_gen
module tb_eth_test_frame_gen;

   logic        clk = 1'b0;
   logic        rst, enable, trigger, tready;
   logic [7:0]  tdata;
   logic        tvalid, tlast, tuser, busy;
   logic [31:0] frame_count;
   logic        enable2, tready2;
   logic [7:0]  tdata2;
   logic        tvalid2, tlast2, tuser2, busy2;
   logic [31:0] frame_count2;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   logic [8:0] cap_q[$];
   int         cap_cyc[$];
   logic [8:0] q2[$];
   int         q2_cyc[$];

   always #4 clk = ~clk;

   eth_test_frame_gen #(.GAP_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .enable(enable), .trigger(trigger),
      .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
      .m_axis_tlast(tlast), .m_axis_tuser(tuser), .busy(busy), .frame_count(frame_count)
   );

   eth_test_frame_gen #(.PAYLOAD_LEN(300), .GAP_CYCLES(0)) dut2 (
      .clk(clk), .rst(rst), .enable(enable2), .trigger(1'b0),
      .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2), .m_axis_tready(tready2),
      .m_axis_tlast(tlast2), .m_axis_tuser(tuser2), .busy(busy2), .frame_count(frame_count2)
   );

   // capture every handshake (tlast, tdata) with its cycle number
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (!rst && tvalid && tready) begin
         cap_q.push_back({tlast, tdata});
         cap_cyc.push_back(cyc);
      end
      if (!rst && tvalid2 && tready2) begin
         q2.push_back({tlast2, tdata2});
         q2_cyc.push_back(cyc);
      end
   end

   function automatic logic [7:0] exp_byte(input int i, input logic [31:0] s);
      logic [31:0] t;
      if (i < 6)   return 8'hFF;
      if (i == 6)  return 8'h02;
      if (i < 11)  return 8'h00;
      if (i == 11) return 8'h01;
      if (i == 12) return 8'h88;
      if (i == 13) return 8'hB5;
      if (i < 18) begin
         t = s << (8 * (i - 14));
         return t[31:24];
      end
      t = 32'(i - 18);
      return t[7:0];
   endfunction

   task automatic do_reset();
      enable = 1'b0; trigger = 1'b0; tready = 1'b1; enable2 = 1'b0; tready2 = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_cmp++;
      if ({tvalid, tlast, tdata, busy, tuser} !== 12'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got v=%0b l=%0b d=%h busy=%0b user=%0b, want all 0", tvalid, tlast, tdata, busy, tuser);
      end
      n_cmp++;
      if (frame_count !== 32'd0) begin
         n_err++;
         $display("FAIL reset_frame_count: got %0d want 0", frame_count);
      end
      n_cmp++;
      if ({tvalid2, busy2, frame_count2} !== 34'd0) begin
         n_err++;
         $display("FAIL reset_dut2: got v=%0b busy=%0b fc=%0d want 0", tvalid2, busy2, frame_count2);
      end
   endtask

   task automatic test_first_frame();
      int base;
      logic [8:0] w, e;
      base = cap_q.size();
      @(posedge clk); #1 enable = 1'b1;
      for (int i = 0; i < 300 && cap_q.size() < base + 60; i++) @(posedge clk);
      #1;
      n_cmp++;
      if (cap_q.size() < base + 60) begin
         n_err++;
         $display("FAIL t1_timeout: got %0d bytes want 60", cap_q.size() - base);
         return;
      end
      for (int i = 0; i < 60; i++) begin
         w = cap_q[base + i];
         e = {(i == 59), exp_byte(i, 32'd0)};
         n_cmp++;
         if (w !== e) begin
            n_err++;
            $display("FAIL t1_byte%0d: got last=%0b data=%h want last=%0b data=%h", i, w[8], w[7:0], e[8], e[7:0]);
         end
      end
      n_cmp++;
      if (frame_count !== 32'd1) begin
         n_err++;
         $display("FAIL t1_frame_count: got %0d want 1", frame_count);
      end
   endtask

   task automatic test_gap_and_seq();
      int base;
      logic [8:0] w, e;
      base = cap_q.size() - 60;
      for (int i = 0; i < 300 && cap_q.size() < base + 120; i++) @(posedge clk);
      #1;
      n_cmp++;
      if (cap_q.size() < base + 120) begin
         n_err++;
         $display("FAIL t2_timeout: got %0d bytes want 120", cap_q.size() - base);
         return;
      end
      n_cmp++;
      if (cap_cyc[base + 60] - cap_cyc[base + 59] !== 5) begin
         n_err++;
         $display("FAIL t2_gap: got %0d idle cycles want 4", cap_cyc[base + 60] - cap_cyc[base + 59] - 1);
      end
      for (int i = 0; i < 60; i++) begin
         w = cap_q[base + 60 + i];
         e = {(i == 59), exp_byte(i, 32'd1)};
         n_cmp++;
         if (w !== e) begin
            n_err++;
            $display("FAIL t2_byte%0d: got last=%0b data=%h want last=%0b data=%h", i, w[8], w[7:0], e[8], e[7:0]);
         end
      end
   endtask

   task automatic test_backpressure();
      int base;
      logic was_stall;
      logic [8:0] held, w, e;
      base = cap_q.size();
      was_stall = 1'b0;
      held = '0;
      for (int i = 0; i < 3000 && cap_q.size() < base + 180; i++) begin
         @(negedge clk);
         if (was_stall) begin
            n_cmp++;
            if (tvalid !== 1'b1 || {tlast, tdata} !== held) begin
               n_err++;
               $display("FAIL t3_stall_hold: got v=%0b l=%0b d=%h want v=1 l=%0b d=%h", tvalid, tlast, tdata, held[8], held[7:0]);
            end
         end
         was_stall = tvalid && !tready;
         held = {tlast, tdata};
         @(posedge clk);
         #1 tready = 1'($urandom_range(0, 1));
      end
      tready = 1'b1;
      n_cmp++;
      if (cap_q.size() < base + 180) begin
         n_err++;
         $display("FAIL t3_timeout: got %0d bytes want 180", cap_q.size() - base);
         return;
      end
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 60; i++) begin
            w = cap_q[base + 60 * f + i];
            e = {(i == 59), exp_byte(i, 32'(f + 2))};
            n_cmp++;
            if (w !== e) begin
               n_err++;
               $display("FAIL t3_f%0d_byte%0d: got last=%0b data=%h want last=%0b data=%h", f, i, w[8], w[7:0], e[8], e[7:0]);
            end
         end
      end
   endtask

   task automatic test_enable_drop();
      int base;
      logic [8:0] w, e;
      do_reset();
      base = cap_q.size();
      enable = 1'b1;
      for (int i = 0; i < 200 && cap_q.size() < base + 20; i++) @(posedge clk);
      #1 enable = 1'b0;
      for (int i = 0; i < 200 && cap_q.size() < base + 60; i++) @(posedge clk);
      repeat (20) @(posedge clk);
      #1;
      n_cmp++;
      if (cap_q.size() !== base + 60) begin
         n_err++;
         $display("FAIL t4_byte_total: got %0d want 60", cap_q.size() - base);
         return;
      end
      for (int i = 0; i < 60; i++) begin
         w = cap_q[base + i];
         e = {(i == 59), exp_byte(i, 32'd0)};
         n_cmp++;
         if (w !== e) begin
            n_err++;
            $display("FAIL t4_byte%0d: got last=%0b data=%h want last=%0b data=%h", i, w[8], w[7:0], e[8], e[7:0]);
         end
      end
      n_cmp++;
      if ({tvalid, busy} !== 2'b00 || frame_count !== 32'd1) begin
         n_err++;
         $display("FAIL t4_idle: got v=%0b busy=%0b fc=%0d want 0 0 1", tvalid, busy, frame_count);
      end
   endtask

   task automatic test_trigger();
      int base;
      logic [8:0] w, e;
      do_reset();
      base = cap_q.size();
      @(posedge clk); #1 trigger = 1'b1;
      @(posedge clk); #1 trigger = 1'b0;
      for (int i = 0; i < 200 && cap_q.size() < base + 10; i++) @(posedge clk);
      #1 trigger = 1'b1;
      @(posedge clk); #1 trigger = 1'b0;
      for (int i = 0; i < 200 && cap_q.size() < base + 40; i++) @(posedge clk);
      #1 trigger = 1'b1;
      @(posedge clk); #1 trigger = 1'b0;
      repeat (200) @(posedge clk);
      #1;
      n_cmp++;
      if (cap_q.size() !== base + 60) begin
         n_err++;
         $display("FAIL t5_byte_total: got %0d want 60", cap_q.size() - base);
         return;
      end
      for (int i = 0; i < 60; i++) begin
         w = cap_q[base + i];
         e = {(i == 59), exp_byte(i, 32'd0)};
         n_cmp++;
         if (w !== e) begin
            n_err++;
            $display("FAIL t5_byte%0d: got last=%0b data=%h want last=%0b data=%h", i, w[8], w[7:0], e[8], e[7:0]);
         end
      end
      n_cmp++;
      if (frame_count !== 32'd1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL t5_count: got fc=%0d busy=%0b want 1 0", frame_count, busy);
      end
   endtask

   task automatic test_reset_mid_frame();
      int base;
      logic [8:0] w, e;
      do_reset();
      base = cap_q.size();
      enable = 1'b1;
      for (int i = 0; i < 200 && cap_q.size() < base + 30; i++) @(posedge clk);
      #1;
      n_cmp++;
      if (tvalid !== 1'b1) begin
         n_err++;
         $display("FAIL t6_pre_valid: got %0b want 1", tvalid);
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({tvalid, tlast, busy} !== 3'b000 || frame_count !== 32'd0) begin
         n_err++;
         $display("FAIL t6_async_reset: got v=%0b l=%0b busy=%0b fc=%0d want 0 0 0 0", tvalid, tlast, busy, frame_count);
      end
      @(posedge clk); #1 rst = 1'b0;
      base = cap_q.size();
      for (int i = 0; i < 200 && cap_q.size() < base + 60; i++) @(posedge clk);
      #1 enable = 1'b0;
      n_cmp++;
      if (cap_q.size() < base + 60) begin
         n_err++;
         $display("FAIL t6_timeout: got %0d bytes want 60", cap_q.size() - base);
         return;
      end
      for (int i = 0; i < 60; i++) begin
         w = cap_q[base + i];
         e = {(i == 59), exp_byte(i, 32'd0)};
         n_cmp++;
         if (w !== e) begin
            n_err++;
            $display("FAIL t6_byte%0d: got last=%0b data=%h want last=%0b data=%h", i, w[8], w[7:0], e[8], e[7:0]);
         end
      end
   endtask

   task automatic test_long_payload_no_gap();
      int base;
      logic [8:0] w, e;
      do_reset();
      base = q2.size();
      enable2 = 1'b1;
      for (int i = 0; i < 1500 && q2.size() < base + 628; i++) @(posedge clk);
      #1 enable2 = 1'b0;
      n_cmp++;
      if (q2.size() < base + 628) begin
         n_err++;
         $display("FAIL t7_timeout: got %0d bytes want 628", q2.size() - base);
         return;
      end
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 314; i++) begin
            w = q2[base + 314 * f + i];
            e = {(i == 313), exp_byte(i, 32'(f))};
            n_cmp++;
            if (w !== e) begin
               n_err++;
               $display("FAIL t7_f%0d_byte%0d: got last=%0b data=%h want last=%0b data=%h", f, i, w[8], w[7:0], e[8], e[7:0]);
            end
         end
      end
      n_cmp++;
      if (q2[base + 274] !== 9'h000) begin
         n_err++;
         $display("FAIL t7_payload256: got %h want 000", q2[base + 274]);
      end
      n_cmp++;
      if (q2_cyc[base + 314] - q2_cyc[base + 313] !== 1) begin
         n_err++;
         $display("FAIL t7_no_gap: got %0d idle cycles want 0", q2_cyc[base + 314] - q2_cyc[base + 313] - 1);
      end
      n_cmp++;
      if (frame_count2 !== 32'd2) begin
         n_err++;
         $display("FAIL t7_frame_count: got %0d want 2", frame_count2);
      end
   endtask

   initial begin
      rst = 1'b1;
      do_reset();
      test_reset();
      test_first_frame();
      test_gap_and_seq();
      test_backpressure();
      test_enable_drop();
      test_trigger();
      test_reset_mid_frame();
      test_long_payload_no_gap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
